nic_interface: RTL and testbench

- Network interface controller directly downstream of the 3-stage pipeline's NIC port.
- Consumes nicEn, nicEnWr, adder_nic and nic_dataIn from the pipeline, and produces nic_dataOut, which the pipeline's stage-3 load mux consumes.
- Bridges the processor to the router through one single-entry input channel and one single-entry output channel, each with a full/empty status register and a valid/ready handshake.

---
 rtl/nic_interface.sv | 114 +++++++++++
 tb/tb_nic_interface.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nic_interface.sv
// nic_interface: memory-mapped NIC bridging the pipeline's NIC port to a router.
//
// Ports:
//   clk, rst           - clock (rising edge) and asynchronous active-low reset
//   addr               - register select: 00 in-buffer, 01 in-status, 10 out-buffer, 11 out-status
//   d_in / d_out       - store data from pipeline / registered load data to pipeline
//   nicEn, nicEnWr     - access strobe and write (1) / read (0) select
//   net_si/net_ri/net_di - incoming flit channel (router valid, NIC ready, data)
//   net_so/net_ro/net_do - outgoing flit channel (NIC valid, router ready, data)
//   net_polarity       - router's current virtual-channel polarity
//
// Each direction is a single-entry buffer with a full flag. The processor
// drains the input buffer by reading addr 00 and fills the output buffer by
// writing addr 10; status is visible at addr 01 / 11.
module nic_interface #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam logic [1:0] AddrInBuf     = 2'b00;
    localparam logic [1:0] AddrInStatus  = 2'b01;
    localparam logic [1:0] AddrOutBuf    = 2'b10;
    localparam logic [1:0] AddrOutStatus = 2'b11;

    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
    logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d;
    logic                  in_full_q, in_full_d;
    logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
    logic                  out_full_q, out_full_d;

    logic rd_en;
    logic wr_en;
    logic in_accept;
    logic out_drain;

    assign rd_en = nicEn & ~nicEnWr;
    assign wr_en = nicEn & nicEnWr;

    assign net_ri = ~in_full_q;
    // A flit is offered only while its VC bit matches the router polarity.
    assign net_so = out_full_q & (out_buf_q[DATA_WIDTH-1] == net_polarity);
    assign net_do = out_buf_q;
    assign d_out  = d_out_q;

    assign in_accept = net_si & net_ri;
    assign out_drain = net_so & net_ro;

    always_comb begin
        d_out_d    = d_out_q;
        in_buf_d   = in_buf_q;
        in_full_d  = in_full_q;
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;

        if (rd_en) begin
            unique case (addr)
                AddrInBuf: begin
                    d_out_d   = in_buf_q;
                    in_full_d = 1'b0;
                end
                AddrInStatus:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
                AddrOutStatus: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full_q};
                default:       d_out_d = '0;
            endcase
        end

        // Accept only happens while empty, so it never collides with a pop.
        if (in_accept) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end

        if (out_drain) begin
            out_full_d = 1'b0;
        end

        // Uses pre-edge status: a write in the draining cycle is dropped.
        if (wr_en && (addr == AddrOutBuf) && !out_full_q) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out_q    <= '0;
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
        end else begin
            d_out_q    <= d_out_d;
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end

endmodule

// File: tb/tb_nic_interface.sv
// Self-checking bench for nic_interface: directed steps then random traffic,
// checked against a queue-based model of the two single-entry channels.
module tb_nic_interface;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  addr = '0;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicEnWr = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [63:0] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [63:0] net_do;
    logic        net_polarity = 1'b0;

    nic_interface #(.DATA_WIDTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: each channel is a queue holding at most one flit; the last
    // flit written into each buffer is remembered since it stays readable.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] last_in  = '0;
    logic [63:0] last_out = '0;
    logic [63:0] exp_dout = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        in_q.delete();
        out_q.delete();
        last_in  = '0;
        last_out = '0;
        exp_dout = '0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance
    // the model, then check the registered load data after the edge.
    task automatic step(input logic en, input logic wr, input logic [1:0] a,
                        input logic [63:0] din, input logic si, input logic [63:0] di,
                        input logic ro, input logic pol);
        bit in_was_full, out_was_full, exp_ri, exp_so;
        nicEn = en; nicEnWr = wr; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
        #1;
        in_was_full  = (in_q.size() != 0);
        out_was_full = (out_q.size() != 0);
        exp_ri = !in_was_full;
        exp_so = out_was_full && (last_out[63] == pol);
        chk("net_ri", {63'b0, net_ri}, {63'b0, exp_ri});
        chk("net_so", {63'b0, net_so}, {63'b0, exp_so});
        chk("net_do", net_do, last_out);
        if (en && !wr) begin
            case (a)
                2'd0: exp_dout = last_in;
                2'd1: exp_dout = {63'b0, in_was_full};
                2'd2: exp_dout = '0;
                default: exp_dout = {63'b0, out_was_full};
            endcase
        end
        if (en && !wr && a == 2'd0 && in_was_full) void'(in_q.pop_front());
        if (si && exp_ri) begin
            in_q.push_back(di);
            last_in = di;
        end
        if (exp_so && ro) void'(out_q.pop_front());
        if (en && wr && a == 2'd2 && !out_was_full) begin
            out_q.push_back(din);
            last_out = din;
        end
        @(posedge clk);
        #1;
        chk("d_out", d_out, exp_dout);
    endtask

    task automatic idle(input logic ro, input logic pol);
        step(1'b0, 1'b0, 2'd0, '0, 1'b0, '0, ro, pol);
    endtask

    initial begin
        // Power-on reset.
        model_clear();
        #2;
        chk("rst_dout", d_out, '0);
        chk("rst_ri", {63'b0, net_ri}, 64'd1);
        chk("rst_so", {63'b0, net_so}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Fill both channels, make d_out nonzero, then reset mid-stream.
        step(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'h1234, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_0042, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_so", {63'b0, net_so}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        chk("arst_dout", d_out, '0);
        chk("arst_ri", {63'b0, net_ri}, 64'd1);
        chk("arst_so", {63'b0, net_so}, 64'd0);
        chk("arst_do", net_do, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);  // in_buf cleared
        step(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);  // out_full cleared

        // Input capture, status read, buffer read.
        step(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'hAAAA_0000_0000_0001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("in_status", d_out, 64'd1);
        step(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("in_read", d_out, 64'hAAAA_0000_0000_0001);
        idle(1'b0, 1'b0);

        // Backpressure: second flit waits until the buffer is freed.
        step(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'hAAAA_0000_0000_0001, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'h5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, '0, 1'b1, 64'h5, 1'b0, 1'b0);
        chk("bp_first", d_out, 64'hAAAA_0000_0000_0001);
        step(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'h5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("bp_second", d_out, 64'h5);
        // Empty read returns stale data.
        step(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Output gated by polarity.
        step(1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_0007, 1'b0, '0, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        step(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("out_drained", d_out, 64'd0);

        // Back-to-back writes while full: second dropped.
        step(1'b1, 1'b1, 2'd2, 64'h1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 64'h2, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("out_full", d_out, 64'd1);
        chk("out_kept", net_do, 64'h1);
        // Write ignored at other addresses, write in the draining cycle dropped.
        step(1'b1, 1'b1, 2'd0, 64'h9, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 64'h3, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("drain_wr_drop", d_out, 64'd0);

        // Simultaneous input accept and output drain.
        step(1'b1, 1'b1, 2'd2, 64'h77, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'h33, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("sim_in_full", d_out, 64'd1);
        step(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("sim_out_empty", d_out, 64'd0);
        step(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("sim_in_data", d_out, 64'h33);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
